// File: rtl/bus_memtest_master.sv
// Bus memory-test master: writes an incrementing pattern (seed + i) to a
// block of 16-bit words, reads it back, counts mismatches and reports
// pass/fail. A per-transaction wait counter aborts the run if the responder
// never acknowledges.
module bus_memtest_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        start,
    input  logic [18:0] base_address,
    input  logic [17:0] word_count,
    input  logic [15:0] seed,
    output logic [18:0] address,
    output logic        bus_enable,
    output logic [1:0]  byte_enable,
    output logic        rw,
    output logic [15:0] write_data,
    input  logic        acknowledge,
    input  logic [15:0] read_data,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timed_out,
    output logic [15:0] error_count,
    output logic [18:0] first_fail_addr
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WR_REQ = 3'd1;
    localparam logic [2:0] S_WR_GAP = 3'd2;
    localparam logic [2:0] S_RD_REQ = 3'd3;
    localparam logic [2:0] S_RD_GAP = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // Last wait-counter value before the abort fires.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    logic [2:0]  state_q, state_d;
    logic [18:0] base_q, base_d;
    logic [17:0] count_q, count_d;
    logic [15:0] seed_q, seed_d;
    logic [17:0] index_q, index_d;
    logic [18:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] wait_q, wait_d;
    logic [15:0] err_q, err_d;
    logic [18:0] fail_addr_q, fail_addr_d;
    logic        timed_out_q, timed_out_d;
    logic        pass_q, pass_d;
    logic [17:0] index_inc;
    logic        result_ok;

    assign index_inc = index_q + 18'd1;
    assign result_ok = (err_q == 16'd0) && !timed_out_q;

    // Next-state, address/pattern generation, checking and timeout logic.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        seed_d      = seed_q;
        index_d     = index_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wait_d      = wait_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        timed_out_d = timed_out_q;
        pass_d      = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Bit 0 of the base is forced low so every access is word aligned.
                    base_d      = base_address & 19'h7FFFE;
                    addr_d      = base_address & 19'h7FFFE;
                    count_d     = word_count;
                    seed_d      = seed;
                    data_d      = seed;
                    index_d     = 18'd0;
                    wait_d      = 16'd0;
                    err_d       = 16'd0;
                    fail_addr_d = 19'd0;
                    timed_out_d = 1'b0;
                    pass_d      = 1'b0;
                    state_d     = (word_count == 18'd0) ? S_DONE : S_WR_REQ;
                end
            end
            S_WR_REQ, S_RD_REQ: begin
                if (acknowledge) begin
                    if (state_q == S_RD_REQ && read_data != data_q) begin
                        if (err_q != 16'hFFFF) begin
                            err_d = err_q + 16'd1;
                        end
                        if (err_q == 16'd0) begin
                            fail_addr_d = addr_q;
                        end
                    end
                    index_d = index_inc;
                    addr_d  = addr_q + 19'd2;
                    data_d  = data_q + 16'd1;
                    wait_d  = 16'd0;
                    if (state_q == S_WR_REQ) begin
                        state_d = S_WR_GAP;
                    end else begin
                        // The final read goes straight to DONE; DONE already
                        // holds bus_enable low, so it doubles as the last gap.
                        state_d = (index_inc < count_q) ? S_RD_GAP : S_DONE;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    timed_out_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_WR_GAP: begin
                if (index_q < count_q) begin
                    state_d = S_WR_REQ;
                end else begin
                    index_d = 18'd0;
                    addr_d  = base_q;
                    data_d  = seed_q;
                    state_d = S_RD_REQ;
                end
            end
            S_RD_GAP: begin
                state_d = (index_q < count_q) ? S_RD_REQ : S_DONE;
            end
            S_DONE: begin
                pass_d  = result_ok;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset of every output-visible flop.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q     <= S_IDLE;
            base_q      <= 19'd0;
            count_q     <= 18'd0;
            seed_q      <= 16'd0;
            index_q     <= 18'd0;
            addr_q      <= 19'd0;
            data_q      <= 16'd0;
            wait_q      <= 16'd0;
            err_q       <= 16'd0;
            fail_addr_q <= 19'd0;
            timed_out_q <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            seed_q      <= seed_d;
            index_q     <= index_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            timed_out_q <= timed_out_d;
            pass_q      <= pass_d;
        end
    end

    assign bus_enable      = (state_q == S_WR_REQ) || (state_q == S_RD_REQ);
    assign rw              = (state_q != S_WR_REQ);
    assign address         = addr_q;
    assign write_data      = data_q;
    assign byte_enable     = 2'b11;
    assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done            = (state_q == S_DONE);
    // The result is shown live during DONE and held afterwards.
    assign pass            = (state_q == S_DONE) ? result_ok : pass_q;
    assign timed_out       = timed_out_q;
    assign error_count     = err_q;
    assign first_fail_addr = fail_addr_q;

endmodule
